// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: opcodes, width limits and EX-stage record shared by reg_alu_pipe
package reg_alu_pkg;
  localparam int OPSize = 3;
  localparam int DAMax = 64;
  localparam int ADMax = 16;
  typedef enum logic [OPSize-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_e;
  typedef struct packed {
    logic [DAMax-1:0] A;
    logic [DAMax-1:0] B;
    op_e              op;
    logic             S;
    logic             WB;
    logic [ADMax-1:0] WB_ADDR;
    logic             valid;
  } ex_stage_t;
endpackage

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2**AW x DW register file, two async reads, load + write-back ports (write-back wins)
// ports: clk, rst (sync, active-low, clears all words), ld_we/ld_addr/ld_data load port,
//        wb_we/wb_addr/wb_data write-back port, rd_addr_1/2 -> rd_data_1/2 combinational reads
module reg_file_mp #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] rd_addr_1,
  input  logic [AW-1:0] rd_addr_2,
  output logic [DW-1:0] rd_data_1,
  output logic [DW-1:0] rd_data_2
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] mem_d [2**AW];
  assign rd_data_1 = mem_q[rd_addr_1];
  assign rd_data_2 = mem_q[rd_addr_2];
  always_comb begin
    mem_d = mem_q;
    if (ld_we) mem_d[ld_addr] = ld_data;
    if (wb_we) mem_d[wb_addr] = wb_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: register file feeding a 2-stage valid/ready ALU pipeline with write-back and sticky overflow
// ports: clk, rst (sync, active-low); Write/Write_ADDR/DIN load port;
//        in_valid/in_ready + Read_ADDR_1/2, OP, S, WB, WB_ADDR op command;
//        out_valid/out_ready + alu_result, Overflow result; ovf_sticky, clr_ovf sticky overflow
// build option: define REG_ALU_FWD_EN to bypass EX results to a dependent issue instead of stalling
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter int DASize = 32,
  parameter int ADSize = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Write,
  input  logic [ADSize-1:0] Write_ADDR,
  input  logic [DASize-1:0] DIN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADSize-1:0] Read_ADDR_1,
  input  logic [ADSize-1:0] Read_ADDR_2,
  input  logic [2:0]        OP,
  input  logic              S,
  input  logic              WB,
  input  logic [ADSize-1:0] WB_ADDR,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DASize-1:0] alu_result,
  output logic              Overflow,
  output logic              ovf_sticky,
  input  logic              clr_ovf
);
  localparam int SHW = $clog2(DASize);
  localparam int M = DASize - 1;
  ex_stage_t ex_q, ex_d;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d, sticky_q, sticky_d;
  logic [DASize-1:0] res_q, res_d;
  logic [DASize-1:0] rd1, rd2, a, b, opa, opb, alu_res;
  logic [DASize:0] sum, diff;
  logic [SHW-1:0] sh;
  logic [ADSize-1:0] ex_wb_addr;
  logic alu_ovf, out_free, ex_adv, issue, hit1, hit2, hazard_stall, unused_ex;
  assign a = ex_q.A[DASize-1:0];
  assign b = ex_q.B[DASize-1:0];
  assign ex_wb_addr = ex_q.WB_ADDR[ADSize-1:0];
  assign unused_ex = ^{ex_q.A, ex_q.B, ex_q.WB_ADDR};
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    sh = b[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (ex_q.op)
      OP_ADD: begin
        alu_res = sum[M:0];
        alu_ovf = ex_q.S ? (a[M] == b[M]) && (sum[M] != a[M]) : sum[DASize];
      end
      OP_SUB: begin
        alu_res = diff[M:0];
        alu_ovf = ex_q.S ? (a[M] != b[M]) && (diff[M] != a[M]) : diff[DASize];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLL: alu_res = a << sh;
      OP_SRL: alu_res = a >> sh;
      OP_SRA: alu_res = $unsigned($signed(a) >>> sh);
      default: alu_res = '0;
    endcase
  end
  assign hit1 = ex_q.valid & ex_q.WB & (Read_ADDR_1 == ex_wb_addr);
  assign hit2 = ex_q.valid & ex_q.WB & (Read_ADDR_2 == ex_wb_addr);
`ifdef REG_ALU_FWD_EN
  assign hazard_stall = 1'b0;
  assign opa = hit1 ? alu_res : rd1;
  assign opb = hit2 ? alu_res : rd2;
`else
  assign hazard_stall = hit1 | hit2;
  assign opa = rd1;
  assign opb = rd2;
`endif
  assign out_free = !out_valid_q | out_ready;
  assign ex_adv = ex_q.valid & out_free;
  assign in_ready = rst & (!ex_q.valid | out_free) & !hazard_stall;
  assign issue = in_valid & in_ready;
  always_comb begin
    ex_d = ex_q;
    ex_d.valid = ex_q.valid & !ex_adv;
    if (issue) begin
      ex_d.A = DAMax'(opa);
      ex_d.B = DAMax'(opb);
      ex_d.op = op_e'(OP);
      ex_d.S = S;
      ex_d.WB = WB;
      ex_d.WB_ADDR = ADMax'(WB_ADDR);
      ex_d.valid = 1'b1;
    end
    out_valid_d = out_free ? ex_q.valid : 1'b1;
    res_d = ex_adv ? alu_res : res_q;
    ovf_d = ex_adv ? alu_ovf : ovf_q;
    sticky_d = (out_valid_q & out_ready & ovf_q) | (sticky_q & !clr_ovf);
  end
  always_ff @(posedge clk) begin
    ex_q <= !rst ? '0 : ex_d;
    out_valid_q <= !rst ? 1'b0 : out_valid_d;
    res_q <= !rst ? '0 : res_d;
    ovf_q <= !rst ? 1'b0 : ovf_d;
    sticky_q <= !rst ? 1'b0 : sticky_d;
  end
  assign out_valid = out_valid_q;
  assign alu_result = res_q;
  assign Overflow = ovf_q;
  assign ovf_sticky = sticky_q;
  reg_file_mp #(.DW(DASize), .AW(ADSize)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ld_we    (Write),
    .ld_addr  (Write_ADDR),
    .ld_data  (DIN),
    .wb_we    (ex_adv & ex_q.WB),
    .wb_addr  (ex_wb_addr),
    .wb_data  (alu_res),
    .rd_addr_1(Read_ADDR_1),
    .rd_addr_2(Read_ADDR_2),
    .rd_data_1(rd1),
    .rd_data_2(rd2)
  );
endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb_reg_alu_pipe: table vectors plus hand sequences, scoreboard queue checked on each accepted result
module tb_reg_alu_pipe;
  logic clk = 1'b0, rst = 1'b0;
  logic Write = 1'b0, in_valid = 1'b0, S = 1'b0, WB = 1'b0, out_ready = 1'b1, clr_ovf = 1'b0;
  logic [4:0] Write_ADDR = '0, Read_ADDR_1 = '0, Read_ADDR_2 = '0, WB_ADDR = '0;
  logic [31:0] DIN = '0;
  logic [2:0] OP = '0;
  logic in_ready, out_valid, Overflow, ovf_sticky;
  logic [31:0] alu_result;
  int checks = 0, errors = 0, cyc = 0, w;
  typedef struct {logic [31:0] r; logic o; bit lat; int ic; int id;} sb_t;
  sb_t sb[$];
  int next_id = 0;
  typedef struct {logic [2:0] op; logic s; logic [31:0] a; logic [31:0] b; logic [31:0] r; logic o;} vec_t;
  vec_t vt[17];
  reg_alu_pipe dut (
    .clk(clk), .rst(rst), .Write(Write), .Write_ADDR(Write_ADDR), .DIN(DIN),
    .in_valid(in_valid), .in_ready(in_ready), .Read_ADDR_1(Read_ADDR_1), .Read_ADDR_2(Read_ADDR_2),
    .OP(OP), .S(S), .WB(WB), .WB_ADDR(WB_ADDR), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .Overflow(Overflow), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", alu_result, 32'hDEAD_BEEF);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk($sformatf("result#%0d", e.id), alu_result, e.r);
        chk($sformatf("overflow#%0d", e.id), {31'b0, Overflow}, {31'b0, e.o});
        if (e.lat) chk($sformatf("latency#%0d", e.id), cyc - e.ic, 2);
      end
    end
  end
  task automatic load(input logic [4:0] ad, input logic [31:0] d);
    Write = 1'b1; Write_ADDR = ad; DIN = d;
    @(posedge clk); #1;
    Write = 1'b0;
  endtask
  task automatic issue(input logic [4:0] ra, input logic [4:0] rb, input logic [2:0] op, input logic s,
                       input logic wb, input logic [4:0] wa, input logic [31:0] er, input logic eo,
                       input bit lat, output int waits);
    int n = 0;
    Read_ADDR_1 = ra; Read_ADDR_2 = rb; OP = op; S = s; WB = wb; WB_ADDR = wa; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    waits = n;
    if (!in_ready) chk("issue_timeout", 32'd0, 32'd1);
    else begin
      sb.push_back('{r: er, o: eo, lat: lat, ic: cyc, id: next_id});
      next_id++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask
  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("out_valid_wait", {31'b0, out_valid}, 32'd1);
  endtask
  initial begin
    vt[0]  = '{3'b000, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
    vt[1]  = '{3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vt[2]  = '{3'b000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vt[3]  = '{3'b000, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vt[4]  = '{3'b001, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1};
    vt[5]  = '{3'b001, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
    vt[6]  = '{3'b001, 1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b0};
    vt[7]  = '{3'b010, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vt[8]  = '{3'b011, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
    vt[9]  = '{3'b100, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
    vt[10] = '{3'b101, 1'b0, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0};
    vt[11] = '{3'b101, 1'b0, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0};
    vt[12] = '{3'b110, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0};
    vt[13] = '{3'b111, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
    vt[14] = '{3'b111, 1'b0, 32'h4000_0000, 32'h0000_001E, 32'h0000_0001, 1'b0};
    vt[15] = '{3'b001, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vt[16] = '{3'b000, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_alu_result", alu_result, 32'd0);
    chk("rst_overflow", {31'b0, Overflow}, 32'd0);
    chk("rst_sticky", {31'b0, ovf_sticky}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    load(5'd10, 32'h0000_1234);
    Read_ADDR_1 = 5'd10; Read_ADDR_2 = 5'd10; OP = 3'b000; WB = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_drop%0d", i), {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    issue(5'd10, 5'd10, 3'b011, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, w);
    load(5'd0, 32'h0000_000F);
    load(5'd1, 32'h0000_0001);
    load(5'd2, 32'h0000_0002);
    issue(5'd1, 5'd2, 3'b000, 1'b0, 1'b0, 5'd0, 32'd3, 1'b0, 1'b1, w);
    drain();
    load(5'd3, 32'h7FFF_FFFF);
    issue(5'd3, 5'd1, 3'b000, 1'b1, 1'b0, 5'd0, 32'h8000_0000, 1'b1, 1'b0, w);
    drain();
    chk("sticky_set", {31'b0, ovf_sticky}, 32'd1);
    repeat (3) @(negedge clk);
    chk("sticky_hold", {31'b0, ovf_sticky}, 32'd1);
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("sticky_clear", {31'b0, ovf_sticky}, 32'd0);
    @(posedge clk); #1;
    issue(5'd3, 5'd1, 3'b000, 1'b0, 1'b0, 5'd0, 32'h8000_0000, 1'b0, 1'b0, w);
    drain();
    chk("sticky_unsigned", {31'b0, ovf_sticky}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(5'd3, 5'd1, 3'b000, 1'b1, 1'b0, 5'd0, 32'h8000_0000, 1'b1, 1'b0, w);
    wait_out_valid();
    @(posedge clk); #1;
    out_ready = 1'b1; clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", {31'b0, ovf_sticky}, 32'd1);
    drain();
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    issue(5'd1, 5'd2, 3'b000, 1'b0, 1'b1, 5'd4, 32'd3, 1'b0, 1'b0, w);
    issue(5'd4, 5'd0, 3'b100, 1'b0, 1'b0, 5'd0, 32'h0000_000C, 1'b0, 1'b0, w);
`ifdef REG_ALU_FWD_EN
    chk("hazard_bubbles", w, 0);
`else
    chk("hazard_bubbles", w, 1);
`endif
    drain();
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      load(5'd8, vt[i].a);
      load(5'd9, vt[i].b);
      issue(5'd8, 5'd9, vt[i].op, vt[i].s, 1'b0, 5'd0, vt[i].r, vt[i].o, 1'b0, w);
    end
    drain();
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        issue(5'd1, 5'd2, 3'b000, 1'b0, 1'b1, 5'd6, 32'd3, 1'b0, 1'b0, w);
        issue(5'd2, 5'd1, 3'b001, 1'b0, 1'b1, 5'd7, 32'd1, 1'b0, 1'b0, w);
        issue(5'd0, 5'd2, 3'b011, 1'b0, 1'b1, 5'd12, 32'h0000_000F, 1'b0, 1'b0, w);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_result_held_a", alu_result, 32'd3);
        repeat (2) @(negedge clk);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_result_held_b", alu_result, 32'd3);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk); #1;
    issue(5'd6, 5'd7, 3'b000, 1'b0, 1'b0, 5'd0, 32'd4, 1'b0, 1'b0, w);
    issue(5'd12, 5'd12, 3'b011, 1'b0, 1'b0, 5'd0, 32'h0000_000F, 1'b0, 1'b0, w);
    drain();
    @(posedge clk); #1;
    load(5'd13, 32'h0000_0050);
    load(5'd14, 32'h0000_0005);
    issue(5'd13, 5'd14, 3'b011, 1'b0, 1'b1, 5'd5, 32'h0000_0055, 1'b0, 1'b0, w);
    load(5'd5, 32'h0000_00AA);
    issue(5'd5, 5'd5, 3'b011, 1'b0, 1'b0, 5'd0, 32'h0000_0055, 1'b0, 1'b0, w);
    issue(5'd1, 5'd2, 3'b001, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
